// File: rtl/accum_stim_gen_if.sv
// Write/readback bus between the stimulus generator and the accum block.
// The master drives the write strobe and data; the slave returns the running sum.
interface accum_stim_gen_if #(
  parameter int VAL_W = 32,
  parameter int ACC_W = 64
) ();
  logic             set_val;
  logic [VAL_W-1:0] val;
  logic [ACC_W-1:0] acc;

  modport master (output set_val, output val, input acc);
  modport slave  (input set_val, input val, output acc);
endinterface

// File: rtl/accum_stim_gen.sv
// Stimulus source and readback checker for accum: issues an arithmetic sequence
// of single-cycle writes and compares acc against a 64-bit expected sum after each.
module accum_stim_gen #(
  parameter int VAL_W = 32,
  parameter int ACC_W = 64,
  parameter int CNT_W = 16,
  parameter int GAP_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [VAL_W-1:0] base,
  input  logic [VAL_W-1:0] step,
  input  logic [CNT_W-1:0] count,
  input  logic [GAP_W-1:0] gap,
  accum_stim_gen_if.master bus,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic [CNT_W-1:0] err_idx,
  output logic [ACC_W-1:0] exp_acc
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    CHECK,
    GAP,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);

  state_t           state;
  logic [VAL_W-1:0] cur;
  logic [VAL_W-1:0] step_r;
  logic [CNT_W-1:0] count_r;
  logic [GAP_W-1:0] gap_r;
  logic [CNT_W-1:0] idx;
  logic [GAP_W-1:0] gap_cnt;

  // Outputs are registered on entry to each state, so set_val is already high
  // in the first ISSUE cycle and done is high for exactly the DONE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bus.set_val <= 1'b0;
      bus.val     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      mismatch    <= 1'b0;
      err_idx     <= '0;
      exp_acc     <= '0;
      cur         <= '0;
      step_r      <= '0;
      count_r     <= '0;
      gap_r       <= '0;
      idx         <= '0;
      gap_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            step_r   <= step;
            count_r  <= count;
            gap_r    <= gap;
            exp_acc  <= bus.acc;
            idx      <= '0;
            mismatch <= 1'b0;
            err_idx  <= '0;
            busy     <= 1'b1;
            if (count != '0) begin
              state       <= ISSUE;
              bus.set_val <= 1'b1;
              bus.val     <= base;
              cur         <= base;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end

        ISSUE: begin
          exp_acc     <= exp_acc + ACC_W'(cur);
          cur         <= cur + step_r;
          bus.set_val <= 1'b0;
          bus.val     <= '0;
          state       <= CHECK;
        end

        // accum's sum for the write just issued is visible here; only the
        // first failing index is kept so the report points at the root cause.
        CHECK: begin
          if ((bus.acc != exp_acc) && !mismatch) begin
            mismatch <= 1'b1;
            err_idx  <= idx;
          end
          idx <= idx + CNT_ONE;
          if (idx == count_r - CNT_ONE) begin
            state <= DONE;
            done  <= 1'b1;
          end else if (gap_r == '0) begin
            state       <= ISSUE;
            bus.set_val <= 1'b1;
            bus.val     <= cur;
          end else begin
            state   <= GAP;
            gap_cnt <= gap_r;
          end
        end

        GAP: begin
          if (gap_cnt == GAP_ONE) begin
            state       <= ISSUE;
            bus.set_val <= 1'b1;
            bus.val     <= cur;
          end else begin
            gap_cnt <= gap_cnt - GAP_ONE;
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state       <= IDLE;
          bus.set_val <= 1'b0;
          bus.val     <= '0;
          busy        <= 1'b0;
          done        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_accum_stim_gen.sv
// Scoreboard bench for accum_stim_gen: a behavioural accum drives acc back, the
// stimulus side queues expected writes and run results, a monitor pops and compares.
module tb_accum_stim_gen;

  typedef struct {
    int          cyc;
    logic [31:0] val;
  } wr_t;

  typedef struct {
    int          cyc;
    logic [63:0] acc;
    logic        mm;
    logic [15:0] eidx;
  } dn_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] base;
  logic [31:0] step;
  logic [15:0] count;
  logic [7:0]  gap;
  logic        busy;
  logic        done;
  logic        mismatch;
  logic [15:0] err_idx;
  logic [63:0] exp_acc;

  logic [63:0] acc_q;
  logic        preload_en;
  logic [63:0] preload_val;
  int          wr_cnt;
  int          freeze_from;
  int          cyc;
  int          t0;
  int          checks;
  int          errors;
  logic [63:0] last_exp;
  wr_t         wq[$];
  dn_t         dq[$];

  accum_stim_gen_if #(.VAL_W(32), .ACC_W(64)) bus ();

  accum_stim_gen #(
    .VAL_W(32),
    .ACC_W(64),
    .CNT_W(16),
    .GAP_W(8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .base    (base),
    .step    (step),
    .count   (count),
    .gap     (gap),
    .bus     (bus),
    .busy    (busy),
    .done    (done),
    .mismatch(mismatch),
    .err_idx (err_idx),
    .exp_acc (exp_acc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural accum; writes at or beyond freeze_from are dropped to model a stuck accumulator.
  assign bus.acc = acc_q;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      wr_cnt <= 0;
    end else if (preload_en) begin
      acc_q <= preload_val;
    end else begin
      if (start && !busy) wr_cnt <= 0;
      if (bus.set_val) begin
        wr_cnt <= wr_cnt + 1;
        if (wr_cnt < freeze_from) acc_q <= acc_q + {32'b0, bus.val};
      end
    end
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every cycle the DUT presents a write or a done, pop and compare.
  initial begin : monitor
    logic prev_set;
    wr_t  w;
    dn_t  d;
    prev_set = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_set = 1'b0;
      end else begin
        if (bus.set_val) begin
          check_output("no_back_to_back_write", {63'b0, prev_set}, 64'd0);
          check_output("busy_during_write", {63'b0, busy}, 64'd1);
          if (wq.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_write: val=0x%0h at cycle %0d, required no write", bus.val, cyc - t0);
          end else begin
            w = wq.pop_front();
            check_output("write_cycle", 64'(cyc - t0), 64'(w.cyc));
            check_output("write_val", {32'b0, bus.val}, {32'b0, w.val});
          end
        end else begin
          check_output("val_zero_when_idle", {32'b0, bus.val}, 64'd0);
        end
        prev_set = bus.set_val;
        if (done) begin
          if (dq.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_done: done at cycle %0d, required none", cyc - t0);
          end else begin
            d = dq.pop_front();
            check_output("done_cycle", 64'(cyc - t0), 64'(d.cyc));
            check_output("done_exp_acc", exp_acc, d.acc);
            check_output("done_mismatch", {63'b0, mismatch}, {63'b0, d.mm});
            check_output("done_err_idx", {48'b0, err_idx}, {48'b0, d.eidx});
            check_output("busy_at_done", {63'b0, busy}, 64'd1);
          end
        end
      end
    end
  end

  task automatic preload(input logic [63:0] v);
    preload_val = v;
    preload_en  = 1'b1;
    @(negedge clk);
    preload_en  = 1'b0;
  endtask

  // Reference model: value k is base + k*step (mod 2^32), write k lands at
  // 1 + k*(2+gap); the stuck accum diverges at the first dropped non-zero add.
  task automatic apply_stimulus(input logic [31:0] b, input logic [31:0] s,
                                input logic [15:0] n, input logic [7:0] g);
    logic [63:0] e_sum;
    logic [63:0] a_sum;
    logic [31:0] v;
    logic        mm;
    logic [15:0] ei;
    wr_t         w;
    dn_t         d;
    int          ni;
    int          gi;
    ni    = int'(n);
    gi    = int'(g);
    e_sum = acc_q;
    a_sum = acc_q;
    mm    = 1'b0;
    ei    = '0;
    for (int k = 0; k < ni; k++) begin
      v     = b + s * 32'(k);
      w.cyc = 1 + k * (2 + gi);
      w.val = v;
      wq.push_back(w);
      e_sum = e_sum + {32'b0, v};
      if (k < freeze_from) a_sum = a_sum + {32'b0, v};
      if (!mm && (e_sum != a_sum)) begin
        mm = 1'b1;
        ei = 16'(k);
      end
    end
    d.cyc  = (ni == 0) ? 1 : 2 * ni + (ni - 1) * gi + 1;
    d.acc  = e_sum;
    d.mm   = mm;
    d.eidx = ei;
    dq.push_back(d);
    last_exp = e_sum;
    t0    = cyc;
    start = 1'b1;
    base  = b;
    step  = s;
    count = n;
    gap   = g;
    @(negedge clk);
    start = 1'b0;
    base  = $urandom;
    step  = $urandom;
    count = 16'($urandom_range(1, 20));
    gap   = 8'($urandom_range(0, 5));
  endtask

  task automatic wait_done(input int busy_start_cycle);
    int n;
    n = 0;
    while ((wq.size() != 0 || dq.size() != 0) && n < 3000) begin
      if (cyc - t0 == busy_start_cycle) begin
        start = 1'b1;
        base  = $urandom;
        step  = $urandom;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("[TB] FAIL run_timeout: %0d writes and %0d done pending, required 0", wq.size(), dq.size());
      wq.delete();
      dq.delete();
    end
    @(negedge clk);
    check_output("busy_after_done", {63'b0, busy}, 64'd0);
    check_output("exp_acc_hold", exp_acc, last_exp);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    t0          = 0;
    rst_n       = 1'b0;
    start       = 1'b0;
    base        = '0;
    step        = '0;
    count       = '0;
    gap         = '0;
    preload_en  = 1'b0;
    preload_val = '0;
    freeze_from = 1 << 30;
    repeat (3) @(negedge clk);
    check_output("reset_set_val", {63'b0, bus.set_val}, 64'd0);
    check_output("reset_val", {32'b0, bus.val}, 64'd0);
    check_output("reset_busy", {63'b0, busy}, 64'd0);
    check_output("reset_done", {63'b0, done}, 64'd0);
    check_output("reset_mismatch", {63'b0, mismatch}, 64'd0);
    check_output("reset_err_idx", {48'b0, err_idx}, 64'd0);
    check_output("reset_exp_acc", exp_acc, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] basic run");
    apply_stimulus(32'd1, 32'd1, 16'd4, 8'd0);
    wait_done(-1);
    check_output("basic_exp_acc", exp_acc, 64'd10);

    $display("[TB] wrap and carry");
    preload(64'd0);
    apply_stimulus(32'hFFFF_FFFF, 32'd1, 16'd2, 8'd0);
    wait_done(-1);
    check_output("wrap_exp_acc", exp_acc, 64'h0000_0000_FFFF_FFFF);
    apply_stimulus(32'hFFFF_FFFF, 32'd0, 16'd2, 8'd0);
    wait_done(-1);
    check_output("carry_exp_acc", exp_acc, 64'h0000_0002_FFFF_FFFD);

    $display("[TB] gap with baseline");
    preload(64'd100);
    apply_stimulus(32'd5, 32'd0, 16'd3, 8'd2);
    wait_done(-1);
    check_output("gap_exp_acc", exp_acc, 64'd115);

    $display("[TB] error injection");
    preload(64'd0);
    freeze_from = 1;
    apply_stimulus(32'd1, 32'd1, 16'd4, 8'd0);
    wait_done(-1);
    freeze_from = 1 << 30;
    check_output("err_mismatch_hold", {63'b0, mismatch}, 64'd1);
    check_output("err_idx_hold", {48'b0, err_idx}, 64'd1);
    apply_stimulus(32'd1, 32'd1, 16'd4, 8'd0);
    wait_done(-1);
    check_output("err_cleared", {63'b0, mismatch}, 64'd0);

    $display("[TB] zero count and busy start");
    apply_stimulus(32'd7, 32'd3, 16'd0, 8'd1);
    wait_done(-1);
    apply_stimulus(32'd1, 32'd1, 16'd4, 8'd0);
    wait_done(3);

    $display("[TB] reset mid-run");
    preload(64'd0);
    apply_stimulus(32'd1, 32'd1, 16'd8, 8'd2);
    while (cyc - t0 < 4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_output("midrst_set_val", {63'b0, bus.set_val}, 64'd0);
    check_output("midrst_val", {32'b0, bus.val}, 64'd0);
    check_output("midrst_busy", {63'b0, busy}, 64'd0);
    check_output("midrst_done", {63'b0, done}, 64'd0);
    check_output("midrst_mismatch", {63'b0, mismatch}, 64'd0);
    check_output("midrst_exp_acc", exp_acc, 64'd0);
    wq.delete();
    dq.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    apply_stimulus(32'd1, 32'd1, 16'd4, 8'd0);
    wait_done(-1);
    check_output("post_reset_exp_acc", exp_acc, 64'd10);

    $display("[TB] randomized runs");
    for (int r = 0; r < 10; r++) begin
      preload({$urandom, $urandom});
      if (r % 3 == 2) freeze_from = $urandom_range(0, 5);
      apply_stimulus($urandom, (r % 2 == 0) ? 32'($urandom_range(0, 9)) : $urandom,
                     16'($urandom_range(1, 6)), 8'($urandom_range(0, 3)));
      wait_done(-1);
      freeze_from = 1 << 30;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
